// File: rtl/fnd_display_scheduler.sv
// fnd_display_scheduler
// Time-shares one 4-digit FND display between the stopwatch, DHT and SR04
// producers. Keeps a shadow of each producer's latest value plus its age in
// ms, selects the shown source by button or auto rotation, and drives the
// value, dot mask and blank request to the FND controller.
//
// Optional build macro: SKIP_STALE_EN -- when defined, an advance skips
// stale sources (stays put if both other sources are stale).
//
// Ports:
//   clk, rst        system clock, async active-high reset
//   i_btn_next      one-cycle pulse, advance to next source
//   i_auto_en       level, 1 = automatic rotation every ROTATE_MS
//   i_sw_valid/data, i_dht_valid/data, i_sr04_valid/data  producer inputs
//   o_disp_data     value shown (0..9999)
//   o_src_sel       00 = SW, 01 = DHT, 10 = SR04
//   o_dot           dot mask, bit0 = ones digit
//   o_blank         1 = blank the display (current source stale)
//   o_update        one-cycle pulse when o_disp_data or o_src_sel changed
//
// state  | meaning
// S_SW   | stopwatch shown (o_src_sel 00)
// S_DHT  | temperature/humidity shown (o_src_sel 01)
// S_SR04 | distance shown (o_src_sel 10)
module fnd_display_scheduler #(
    parameter int SYS_CLK_HZ = 100_000_000,
    parameter int ROTATE_MS  = 3000,
    parameter int STALE_MS   = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_btn_next,
    input  logic        i_auto_en,
    input  logic        i_sw_valid,
    input  logic [13:0] i_sw_data,
    input  logic        i_dht_valid,
    input  logic [13:0] i_dht_data,
    input  logic        i_sr04_valid,
    input  logic [11:0] i_sr04_data,
    output logic [13:0] o_disp_data,
    output logic [1:0]  o_src_sel,
    output logic [3:0]  o_dot,
    output logic        o_blank,
    output logic        o_update
);

    localparam int TICK_DIV = SYS_CLK_HZ / 1000;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ROT_W    = (ROTATE_MS > 1) ? $clog2(ROTATE_MS) : 1;
    localparam int AGE_W    = $clog2(STALE_MS + 1);
    localparam logic [13:0]      MAX_VAL   = 14'd9999;
    localparam logic [AGE_W-1:0] AGE_STALE = AGE_W'(STALE_MS);

    typedef enum logic [1:0] {
        S_SW   = 2'b00,
        S_DHT  = 2'b01,
        S_SR04 = 2'b10
    } state_t;

    function automatic logic [13:0] sat14(input logic [13:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    function automatic state_t succ(input state_t s);
        case (s)
            S_SW:    return S_DHT;
            S_DHT:   return S_SR04;
            default: return S_SW;
        endcase
    endfunction

    // ms tick
    logic [TICK_W-1:0] tick_cnt;
    logic              ms_tick;

    assign ms_tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          tick_cnt <= '0;
        else if (ms_tick) tick_cnt <= '0;
        else              tick_cnt <= tick_cnt + 1'b1;
    end

    // Input stage: strobe and saturated data registered first, shadow and
    // age update one cycle later. Index 0 = SW, 1 = DHT, 2 = SR04.
    logic [2:0]       cap_v;
    logic [13:0]      cap_d  [3];
    logic [13:0]      shadow [3];
    logic [AGE_W-1:0] age    [3];
    logic [2:0]       stale;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_v    <= '0;
            cap_d[0] <= '0;
            cap_d[1] <= '0;
            cap_d[2] <= '0;
        end else begin
            cap_v    <= {i_sr04_valid, i_dht_valid, i_sw_valid};
            cap_d[0] <= sat14(i_sw_data);
            cap_d[1] <= sat14(i_dht_data);
            cap_d[2] <= {2'b00, i_sr04_data};
        end
    end

    // A fresh capture wins over a coincident ms tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                shadow[i] <= '0;
                age[i]    <= AGE_STALE;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cap_v[i]) begin
                    shadow[i] <= cap_d[i];
                    age[i]    <= '0;
                end else if (ms_tick && (age[i] != AGE_STALE)) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        stale = '0;
        for (int i = 0; i < 3; i++) stale[i] = (age[i] == AGE_STALE);
    end

    // Source selection FSM
    state_t           state, state_nxt;
    logic [ROT_W-1:0] rot_cnt;
    logic             rot_expire;
    logic             advance;

    assign rot_expire = i_auto_en && ms_tick && (rot_cnt == ROT_W'(ROTATE_MS - 1));
    assign advance    = i_btn_next || rot_expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_SW;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (advance) begin
`ifdef SKIP_STALE_EN
            if (!stale[succ(state)])
                state_nxt = succ(state);
            else if (!stale[succ(succ(state))])
                state_nxt = succ(succ(state));
`else
            state_nxt = succ(state);
`endif
        end
    end

    // Dwell counter restarts on every advance and whenever auto is off, so
    // re-enabling auto always gives a full dwell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        rot_cnt <= '0;
        else if (!i_auto_en || advance) rot_cnt <= '0;
        else if (ms_tick)               rot_cnt <= rot_cnt + 1'b1;
    end

    // Registered outputs
    logic [13:0] disp_nxt;
    logic        blank_nxt;
    logic [3:0]  dot_nxt;

    always_comb begin
        disp_nxt  = shadow[state];
        blank_nxt = stale[state];
        dot_nxt   = 4'b0000;
        if (!blank_nxt && (state != S_SR04)) dot_nxt = 4'b0100;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_disp_data <= '0;
            o_src_sel   <= 2'b00;
            o_dot       <= 4'b0000;
            o_blank     <= 1'b1;
            o_update    <= 1'b0;
        end else begin
            o_disp_data <= disp_nxt;
            o_src_sel   <= state;
            o_dot       <= dot_nxt;
            o_blank     <= blank_nxt;
            o_update    <= (disp_nxt != o_disp_data) || (state != o_src_sel);
        end
    end

endmodule

// File: tb/tb_fnd_display_scheduler.sv
module tb_fnd_display_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_next, auto_en;
    logic        sw_valid, dht_valid, sr04_valid;
    logic [13:0] sw_data, dht_data;
    logic [11:0] sr04_data;
    logic [13:0] disp_data;
    logic [1:0]  src_sel;
    logic [3:0]  dot;
    logic        blank, update;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;

    // edges counted from the first rising edge after reset release
    always @(posedge clk) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    fnd_display_scheduler #(
        .SYS_CLK_HZ(10_000),
        .ROTATE_MS (3),
        .STALE_MS  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_btn_next  (btn_next),
        .i_auto_en   (auto_en),
        .i_sw_valid  (sw_valid),
        .i_sw_data   (sw_data),
        .i_dht_valid (dht_valid),
        .i_dht_data  (dht_data),
        .i_sr04_valid(sr04_valid),
        .i_sr04_data (sr04_data),
        .o_disp_data (disp_data),
        .o_src_sel   (src_sel),
        .o_dot       (dot),
        .o_blank     (blank),
        .o_update    (update)
    );

    // drv: edge after which the pulses are driven (held for one edge)
    // chk: edge after which the outputs are compared
    typedef struct {
        int drv; bit auto_on; bit btn;
        bit sw_v;  int sw_d;
        bit dht_v; int dht_d;
        bit sr_v;  int sr_d;
        int chk;
        int e_data; int e_sel; int e_dot; int e_blank; int e_upd;
    } vec_t;

    vec_t tbl[$];
    vec_t post[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int d, input int s,
                             input int dt, input int b, input int u);
        chk({tag, " data"},   int'(disp_data), d);
        chk({tag, " sel"},    int'(src_sel),   s);
        chk({tag, " dot"},    int'(dot),       dt);
        chk({tag, " blank"},  int'(blank),     b);
        chk({tag, " update"}, int'(update),    u);
    endtask

    task automatic wait_edge(input int e);
        int guard = 0;
        while (edge_cnt < e && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (edge_cnt < e) chk("edge_timeout", edge_cnt, e);
    endtask

    task automatic check_sel(input string tag, input int e, input int exp);
        wait_edge(e);
        chk(tag, int'(src_sel), exp);
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        wait_edge(v.drv);
        auto_en    = v.auto_on;
        btn_next   = v.btn;
        sw_valid   = v.sw_v;   sw_data   = 14'(v.sw_d);
        dht_valid  = v.dht_v;  dht_data  = 14'(v.dht_d);
        sr04_valid = v.sr_v;   sr04_data = 12'(v.sr_d);
        wait_edge(v.drv + 1);
        btn_next = 1'b0; sw_valid = 1'b0; dht_valid = 1'b0; sr04_valid = 1'b0;
        wait_edge(v.chk);
        check_all(tag, v.e_data, v.e_sel, v.e_dot, v.e_blank, v.e_upd);
    endtask

    initial begin
        rst = 1'b1; btn_next = 1'b0; auto_en = 1'b0;
        sw_valid = 1'b0; dht_valid = 1'b0; sr04_valid = 1'b0;
        sw_data = '0; dht_data = '0; sr04_data = '0;

`ifdef SKIP_STALE_EN
        //           drv au bt sw  swd dh dhd  sr srd  chk data sel dot bl up
        tbl.push_back('{0, 0, 0, 0, 0,  0, 0,  1, 100, 2,  0,  0, 0, 1, 0});
        tbl.push_back('{2, 0, 1, 0, 0,  0, 0,  0, 0,   4,  100,2, 0, 0, 1});
        tbl.push_back('{4, 1, 0, 0, 0,  0, 0,  0, 0,   5,  100,2, 0, 0, 0});
        tbl.push_back('{24,1, 1, 0, 0,  0, 0,  0, 0,   26, 100,2, 0, 1, 0});
        tbl.push_back('{27,1, 0, 1, 7,  0, 0,  0, 0,   31, 100,2, 0, 1, 0});
        tbl.push_back('{37,1, 0, 1, 7,  0, 0,  0, 0,   38, 100,2, 0, 1, 0});
        tbl.push_back('{47,1, 0, 1, 7,  0, 0,  0, 0,   51, 7,  0, 4, 0, 1});
        post.push_back('{2, 0, 1, 0, 0, 0, 0,  0, 0,   4,  0,  0, 0, 1, 0});
`else
        tbl.push_back('{0, 0, 0, 1, 1234, 0, 0,     0, 0,    3,  1234, 0, 4, 0, 1});
        tbl.push_back('{3, 0, 0, 0, 0,    0, 0,     0, 0,    4,  1234, 0, 4, 0, 0});
        tbl.push_back('{4, 0, 0, 0, 0,    0, 0,     1, 4095, 6,  1234, 0, 4, 0, 0});
        tbl.push_back('{6, 0, 1, 0, 0,    0, 0,     0, 0,    8,  0,    1, 0, 1, 1});
        tbl.push_back('{8, 0, 1, 0, 0,    0, 0,     0, 0,    10, 4095, 2, 0, 0, 1});
        tbl.push_back('{10,0, 0, 0, 0,    1, 12000, 0, 0,    12, 4095, 2, 0, 0, 0});
        tbl.push_back('{12,0, 1, 0, 0,    0, 0,     0, 0,    14, 1234, 0, 4, 0, 1});
        tbl.push_back('{14,0, 1, 0, 0,    0, 0,     0, 0,    16, 9999, 1, 4, 0, 1});
        tbl.push_back('{16,0, 0, 0, 0,    1, 9999,  0, 0,    18, 9999, 1, 4, 0, 0});
        tbl.push_back('{18,0, 0, 0, 0,    0, 0,     0, 0,    19, 9999, 1, 4, 0, 0});
        tbl.push_back('{19,0, 1, 0, 0,    0, 0,     0, 0,    21, 4095, 2, 0, 1, 1});
        tbl.push_back('{21,0, 1, 0, 0,    0, 0,     0, 0,    23, 1234, 0, 0, 1, 1});
        tbl.push_back('{23,0, 0, 1, 42,   0, 0,     0, 0,    26, 42,   0, 4, 0, 1});
        tbl.push_back('{26,0, 0, 0, 0,    0, 0,     0, 0,    27, 42,   0, 4, 0, 0});
        post.push_back('{2, 0, 1, 0, 0,   0, 0,     0, 0,    3,  0,    0, 0, 1, 0});
        post.push_back('{4, 0, 1, 0, 0,   0, 0,     0, 0,    6,  0,    2, 0, 1, 1});
`endif

        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 1, 0);
        rst = 1'b0;

        foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));

`ifndef SKIP_STALE_EN
        // auto rotation: ticks land on edges 10,20,..; enabled after edge 27
        wait_edge(27);
        auto_en = 1'b1;
        check_sel("rot_hold_50",  50, 0);
        check_sel("rot_adv_51",   51, 1);
        check_sel("rot_hold_80",  80, 1);
        check_sel("rot_adv_81",   81, 2);
        // button coincides with the expiry at edge 110: one advance only
        wait_edge(109);
        btn_next = 1'b1;
        wait_edge(110);
        btn_next = 1'b0;
        check_sel("btn_expiry_111", 111, 0);
        check_sel("dwell_140",      140, 0);
        check_sel("dwell_141",      141, 1);
        // auto off with rot_cnt at 2 freezes; re-enable restarts full dwell
        wait_edge(160);
        auto_en = 1'b0;
        check_sel("frozen_180", 180, 1);
        wait_edge(185);
        auto_en = 1'b1;
        check_sel("restart_191", 191, 1);
        check_sel("restart_210", 210, 1);
        check_sel("restart_211", 211, 2);
        wait_edge(215);
`else
        wait_edge(55);
`endif

        // reset mid-operation
        rst = 1'b1;
        #2;
        check_all("async_rst", 0, 0, 0, 1, 0);
        @(posedge clk); #1;
        check_all("mid_rst", 0, 0, 0, 1, 0);
        auto_en = 1'b0;
        rst = 1'b0;
        foreach (post[i]) apply_vec(post[i], $sformatf("post%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
